ram_burst_rd: RTL and testbench

RAM_BURST_RD -- requirements
Module: ram_burst_rd

---
 rtl/ram_burst_rd_pkg.sv | 21 ++
 rtl/ram_burst_rd_sfifo.sv | 72 +++++++
 rtl/ram_burst_rd.sv | 150 +++++++++++++++
 tb/tb_ram_burst_rd.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_burst_rd_pkg                                          |
// | Purpose  : Shared constants for the RAM burst reader: FSM state      |
// |            encodings and the supported RAM read-latency range.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ram_burst_rd_pkg;

    localparam int unsigned c_state_w = 2;

    localparam logic [c_state_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_state_w-1:0] c_st_run   = 2'd1;
    localparam logic [c_state_w-1:0] c_st_drain = 2'd2;

    // Read latency must match the RAM port pipeline setting.
    localparam int c_lat_min = 1;
    localparam int c_lat_max = 6;

endpackage
`default_nettype wire

// File: rtl/ram_burst_rd_sfifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rd_sfifo                                                  |
// | Purpose  : Small synchronous FIFO buffering RAM read data.           |
// | Ports    : clk, rst (sync, active high), i_push/i_wdata,             |
// |            i_pop/o_rdata (head word), o_count, o_empty               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rd_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == c_ptr_last) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ram_burst_rd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_burst_rd                                              |
// | Purpose  : Reads a burst of consecutive words from a fixed-latency   |
// |            RAM port and streams them out with valid/ready.           |
// | Ports    : clk, rst (sync, active high)                              |
// |            start/sadd/len : burst request (len==0 is a no-op)        |
// |            busy, done     : status, done is a 1-cycle pulse          |
// |            ram_add/ram_rdat : RAM read port                          |
// |            ovld/ordy/odat/olast : output stream                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ram_burst_rd
    import ram_burst_rd_pkg::*;
#(
    parameter int G_ADDR  = 10,
    parameter int G_WIDTH = 16,
    parameter int G_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [G_ADDR-1:0]  sadd,
    input  logic [G_ADDR:0]    len,
    output logic               busy,
    output logic               done,
    output logic [G_ADDR-1:0]  ram_add,
    input  logic [G_WIDTH-1:0] ram_rdat,
    output logic               ovld,
    input  logic               ordy,
    output logic [G_WIDTH-1:0] odat,
    output logic               olast
);

    localparam int c_depth = G_LAT + 2;
    localparam int c_cw    = $clog2(c_depth + 1);

    if ((G_LAT < c_lat_min) || (G_LAT > c_lat_max)) begin : g_bad_lat
        $error("ram_burst_rd: G_LAT outside supported range");
    end

    logic [c_state_w-1:0] r_state;
    logic [G_ADDR-1:0]    r_addr_cnt;
    logic [G_ADDR-1:0]    r_ram_add;
    logic [G_ADDR:0]      r_remaining;
    logic                 r_done;
    logic [G_LAT-1:0]     r_dv;        // read-in-flight markers
    logic [G_LAT-1:0]     r_dl;        // matching last-word markers

    logic [c_cw-1:0]      w_inflight;
    logic [c_cw-1:0]      w_fifo_cnt;
    logic [c_cw:0]        w_credit;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_empty;
    logic [G_WIDTH:0]     w_head;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < G_LAT; k++) begin
            w_inflight = w_inflight + c_cw'(r_dv[k]);
        end
    end

    // Words in flight plus words buffered never exceed the FIFO depth,
    // so every returning word always has a slot.
    assign w_credit = {1'b0, w_inflight} + {1'b0, w_fifo_cnt};
    assign w_issue  = (r_state == c_st_run) && (r_remaining != '0) &&
                      (w_credit < (c_cw + 1)'(c_depth));
    assign w_push   = r_dv[G_LAT-1];
    assign w_pop    = ovld && ordy;

    // The address is presented in the issue cycle itself and held otherwise.
    assign ram_add = w_issue ? r_addr_cnt : r_ram_add;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_addr_cnt  <= '0;
            r_ram_add   <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_dv        <= '0;
            r_dl        <= '0;
        end else begin
            r_done    <= 1'b0;
            r_ram_add <= ram_add;

            r_dv[0] <= w_issue;
            r_dl[0] <= w_issue && (r_remaining == (G_ADDR + 1)'(1));
            for (int k = 1; k < G_LAT; k++) begin
                r_dv[k] <= r_dv[k-1];
                r_dl[k] <= r_dl[k-1];
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (len != '0) begin
                            r_addr_cnt  <= sadd;
                            r_remaining <= len;
                            r_state     <= c_st_run;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_run: begin
                    if (w_issue) begin
                        r_addr_cnt  <= r_addr_cnt + G_ADDR'(1);
                        r_remaining <= r_remaining - (G_ADDR + 1)'(1);
                        if (r_remaining == (G_ADDR + 1)'(1)) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_pop && w_head[G_WIDTH]) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    rd_sfifo #(
        .WIDTH (G_WIDTH + 1),
        .DEPTH (c_depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({r_dl[G_LAT-1], ram_rdat}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fifo_cnt),
        .o_empty (w_fifo_empty)
    );

    assign busy  = (r_state != c_st_idle);
    assign done  = r_done;
    assign ovld  = ~w_fifo_empty;
    assign odat  = w_head[G_WIDTH-1:0];
    assign olast = ovld && w_head[G_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_rd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ram_burst_rd                                           |
// | Purpose  : Self-checking bench for ram_burst_rd at read latencies    |
// |            1, 2 and 3 against a word-sequence reference model.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ram_burst_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start, busy, done, ovld, ordy, olast;
    logic [9:0]  sadd    [3];
    logic [9:0]  ram_add [3];
    logic [9:0]  acnt    [3];
    logic [10:0] len     [3];
    logic [15:0] ram_rdat[3];
    logic [15:0] odat    [3];
    int          fcnt    [3];

    logic [16:0] exp_q[$];          // {last, data} words still owed
    logic [9:0]  ra_log [16];
    logic        prev_stall [3];
    logic [15:0] prev_dat   [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // RAM contents: a fixed scramble of the address.
    function automatic logic [15:0] ram_f(input logic [9:0] a);
        logic [31:0] t;
        t = {22'd0, a} * 32'd40503;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = gi + 1;
        logic [15:0] pipe [L];

        ram_burst_rd #(.G_ADDR(10), .G_WIDTH(16), .G_LAT(L)) u_dut (
            .clk(clk), .rst(rst), .start(start[gi]), .sadd(sadd[gi]),
            .len(len[gi]), .busy(busy[gi]), .done(done[gi]),
            .ram_add(ram_add[gi]), .ram_rdat(ram_rdat[gi]), .ovld(ovld[gi]),
            .ordy(ordy[gi]), .odat(odat[gi]), .olast(olast[gi])
        );

        // RAM read port with an L-stage output pipeline.
        always @(posedge clk) begin
            pipe[0] <= ram_f(ram_add[gi]);
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign ram_rdat[gi] = pipe[L-1];
        assign fcnt[gi]     = int'(u_dut.w_fifo_cnt);
        assign acnt[gi]     = u_dut.r_addr_cnt;
    end

    task automatic fail(input string name, input int act, input int exp);
        errors++;
        $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) fail(name, act, exp);
    endtask

    function automatic logic ordy_val(input int mode, input int cyc);
        case (mode)
            1:       return 1'($urandom_range(0, 1));
            2:       return ((cyc >= 8) && (cyc < 18)) ? 1'b0 : (cyc % 2 == 0);
            default: return 1'b1;
        endcase
    endfunction

    // Per-cycle stream checks at the negedge.
    task automatic sample(input int i);
        if (prev_stall[i]) begin
            checks++;
            if (!ovld[i] || (odat[i] != prev_dat[i]))
                fail("stall_hold", int'(odat[i]), int'(prev_dat[i]));
        end
        if (ovld[i] && ordy[i]) begin
            checks++;
            if (exp_q.size() == 0) begin
                fail("dup_word", int'(odat[i]), -1);
            end else begin
                if ({olast[i], odat[i]} != exp_q[0])
                    fail("word", int'({olast[i], odat[i]}), int'(exp_q[0]));
                exp_q.delete(0);
            end
        end
        if (fcnt[i] > i + 3) begin
            checks++;
            fail("fifo_over", fcnt[i], i + 3);
        end
        prev_stall[i] = ovld[i] && !ordy[i];
        prev_dat[i]   = odat[i];
    endtask

    // Cycle 0 is the cycle in which start is high.
    task automatic run_burst(input int i, input logic [9:0] a, input logic [10:0] n,
                             input int mode, input int poke,
                             output int t_ovld, output int t_done, output int busy_seen);
        int budget;
        @(posedge clk); #1;
        start[i] = 1'b1; sadd[i] = a; len[i] = n; ordy[i] = ordy_val(mode, 0);
        prev_stall[i] = 1'b0;
        for (int k = 0; k < int'(n); k++) begin
            logic [9:0] ad;
            ad = a + 10'(k);
            exp_q.push_back({(k == int'(n) - 1), ram_f(ad)});
        end
        t_ovld = -1; t_done = -1; busy_seen = 0;
        budget = 8 * (int'(n) + 10) + 100;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                start[i] = (cyc == poke);
                if (cyc == poke) begin
                    sadd[i] = a + 10'd100;
                    len[i]  = 11'd5;
                end
                ordy[i] = ordy_val(mode, cyc);
            end
            @(negedge clk);
            if (cyc < 16) ra_log[cyc] = ram_add[i];
            if (busy[i]) busy_seen = 1;
            if (ovld[i] && (t_ovld < 0)) t_ovld = cyc;
            sample(i);
            if (done[i]) begin
                t_done = cyc;
                break;
            end
        end
        if (t_done < 0) begin
            checks++;
            fail("done_timeout", t_done, budget);
        end
        chk("busy_after_done", int'(busy[i]), 0);
        chk("no_lost_words", exp_q.size(), 0);
        exp_q.delete();
        start[i] = 1'b0;
        ordy[i]  = 1'b1;
    endtask

    typedef struct {
        int          inst;
        logic [9:0]  a;
        logic [10:0] n;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int to, td, bs, nd, nv;
        vecs[0] = '{0, 10'h010, 11'd4};
        vecs[1] = '{1, 10'h200, 11'd5};
        vecs[2] = '{2, 10'h3FE, 11'd4};
        vecs[3] = '{0, 10'h3FF, 11'd1};
        vecs[4] = '{2, 10'h000, 11'd0};
        vecs[5] = '{1, 10'h100, 11'd20};

        rst = 1'b1; start = '0; ordy = '1;
        for (int i = 0; i < 3; i++) begin
            sadd[i] = '0; len[i] = '0; prev_stall[i] = 1'b0; prev_dat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy",    int'(busy[i]),    0);
            chk("rst_done",    int'(done[i]),    0);
            chk("rst_ovld",    int'(ovld[i]),    0);
            chk("rst_olast",   int'(olast[i]),   0);
            chk("rst_odat",    int'(odat[i]),    0);
            chk("rst_ram_add", int'(ram_add[i]), 0);
        end

        // Table: latency, one-word-per-cycle throughput, no-op bursts.
        for (int v = 0; v < 6; v++) begin
            int L;
            L = vecs[v].inst + 1;
            run_burst(vecs[v].inst, vecs[v].a, vecs[v].n, 0, -1, to, td, bs);
            chk("first_ovld", to, (vecs[v].n == 0) ? -1 : 2 + L);
            chk("done_cycle", td, (vecs[v].n == 0) ? 1 : 2 + L + int'(vecs[v].n));
            chk("busy_seen",  bs, (vecs[v].n == 0) ? 0 : 1);
        end

        // Address wrap at latency 3, and address hold once issuing stops.
        run_burst(2, 10'h3FE, 11'd4, 0, -1, to, td, bs);
        chk("wrap_add1", int'(ra_log[1]), 'h3FE);
        chk("wrap_add2", int'(ra_log[2]), 'h3FF);
        chk("wrap_add3", int'(ra_log[3]), 'h000);
        chk("wrap_add4", int'(ra_log[4]), 'h001);
        chk("wrap_hold", int'(ra_log[5]), 'h001);

        // Back-pressure: alternating ordy with a long stall.
        run_burst(1, 10'h2F0, 11'd16, 2, -1, to, td, bs);
        chk("toggle_first_ovld", to, 4);

        // Start pulsed mid-burst must be ignored.
        run_burst(1, 10'h080, 11'd6, 0, 3, to, td, bs);
        chk("ignore_start_done", td, 2 + 2 + 6);

        // Reset 3 cycles into a len=8 burst.
        @(posedge clk); #1;
        start[0] = 1'b1; sadd[0] = 10'h040; len[0] = 11'd8; ordy[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",    int'(busy[0]),    0);
        chk("mid_rst_done",    int'(done[0]),    0);
        chk("mid_rst_ovld",    int'(ovld[0]),    0);
        chk("mid_rst_olast",   int'(olast[0]),   0);
        chk("mid_rst_odat",    int'(odat[0]),    0);
        chk("mid_rst_ram_add", int'(ram_add[0]), 0);
        nd = 0; nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (done[0]) nd++;
            if (ovld[0]) nv++;
        end
        chk("mid_rst_no_done", nd, 0);
        chk("mid_rst_no_data", nv, 0);
        exp_q.delete();
        run_burst(0, 10'h123, 11'd2, 0, -1, to, td, bs);
        chk("post_rst_done", td, 2 + 1 + 2);

        // Full-range burst returns the counter to its start address.
        run_burst(0, 10'h155, 11'd1024, 0, -1, to, td, bs);
        chk("full_done", td, 2 + 1 + 1024);
        chk("full_addr_back", int'(acnt[0]), 'h155);

        // Randomized bursts with random back-pressure.
        for (int r = 0; r < 12; r++) begin
            int          i;
            logic [9:0]  a;
            logic [10:0] n;
            i = int'($urandom_range(0, 2));
            a = 10'($urandom);
            n = 11'($urandom_range(0, 40));
            run_burst(i, a, n, 1, -1, to, td, bs);
            if (n == 0) chk("rand_noop_done", td, 1);
            else        chk("rand_first_ovld", to, i + 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
